fetch_sequencer: RTL and testbench

Controls the instruction-fetch path: it owns the 16-word program memory, the program counter and the fetch pipeline register. It loads program memory from a host word stream and runs, single-steps, stalls, jumps or halts the fetch. The core sees a registered instruction with a valid strobe. The block sits between the host/test interface and the execute stage.

---
 rtl/fetch_sequencer.sv | 159 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program memory, program counter and fetch
// pipeline register; loads the memory from a host word stream and runs,
// single-steps, stalls, redirects or halts instruction fetch.
module fetch_sequencer #(
    parameter int unsigned       ADDR_W    = 4,
    parameter int unsigned       DATA_W    = 16,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(16'hFFFF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              run,
    input  logic              step,
    input  logic              stall,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [15:0]       pc,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              halted,
    output logic [1:0]        state
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              ready_q, ready_d;
    logic              mem_we_c;
    logic              fetch_c;
    logic [DATA_W-1:0] fetch_word_c;

    logic [DATA_W-1:0] mem [DEPTH];

    // Word addressed by the current pc; the fetch register captures it.
    assign fetch_word_c = mem[pc_q];

    // Next-state and next-register values for the fetch controller.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ptr_d    = ptr_q;
        instr_d  = instr_q;
        valid_d  = 1'b0;
        halted_d = halted_q;
        ready_d  = ready_q;
        mem_we_c = 1'b0;
        fetch_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_en) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    ready_d = 1'b1;
                end else if (run) begin
                    state_d = RUN;
                end else if (step) begin
                    fetch_c = 1'b1;
                end
            end
            LOAD: begin
                if (!load_en) begin
                    // A word arriving with the falling load_en is dropped.
                    state_d = IDLE;
                    pc_d    = '0;
                    ready_d = 1'b0;
                end else if (load_valid) begin
                    mem_we_c = 1'b1;
                    ptr_d    = ptr_q + ADDR_W'(1);
                end
            end
            RUN: begin
                // Stall freezes everything, including a pending jump.
                if (stall) begin
                    state_d = RUN;
                end else if (!run) begin
                    state_d = IDLE;
                end else if (jump_valid) begin
                    pc_d = jump_target;
                end else begin
                    fetch_c = 1'b1;
                end
            end
            HALT: begin
                if (load_en) begin
                    state_d  = LOAD;
                    halted_d = 1'b0;
                    ptr_d    = '0;
                    ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared fetch op for RUN and IDLE single-step.
        if (fetch_c) begin
            instr_d = fetch_word_c;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
            if (fetch_word_c == HALT_WORD) begin
                state_d  = HALT;
                halted_d = 1'b1;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            ptr_q    <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ptr_q    <= ptr_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            ready_q  <= ready_d;
        end
    end

    // Program memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst && mem_we_c) begin
            mem[ptr_q] <= load_data;
        end
    end

    assign pc          = 16'(pc_q);
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign load_ready  = ready_q;
    assign state       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic        run;
    logic        step;
    logic        stall;
    logic        jump_valid;
    logic [3:0]  jump_target;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        halted;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        le;
        logic        lv;
        logic [15:0] ld;
        logic        run;
        logic        step;
        logic        stall;
        logic        jv;
        logic [3:0]  jt;
        logic [15:0] e_pc;
        logic [15:0] e_ins;
        logic        e_iv;
        logic        e_h;
        logic [1:0]  e_st;
        logic        e_lr;
    } vec_t;

    vec_t vecs[$];

    fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .run         (run),
        .step        (step),
        .stall       (stall),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .halted      (halted),
        .state       (state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input logic le, input logic lv, input logic [15:0] ld,
        input logic rn, input logic st, input logic sl, input logic jv,
        input logic [3:0] jt, input logic [15:0] epc, input logic [15:0] eins,
        input logic eiv, input logic eh, input logic [1:0] est, input logic elr);
        vec_t v;
        v.rst = r;  v.le = le;  v.lv = lv;  v.ld = ld;  v.run = rn;
        v.step = st; v.stall = sl; v.jv = jv; v.jt = jt;
        v.e_pc = epc; v.e_ins = eins; v.e_iv = eiv; v.e_h = eh;
        v.e_st = est; v.e_lr = elr;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector at the falling edge, sample 1 unit after the rising edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst = v.rst; load_en = v.le; load_valid = v.lv; load_data = v.ld;
        run = v.run; step = v.step; stall = v.stall;
        jump_valid = v.jv; jump_target = v.jt;
        @(posedge clk);
        #1;
        check({tag, ".pc"},          pc,                  v.e_pc);
        check({tag, ".instruction"}, instruction,         v.e_ins);
        check({tag, ".instr_valid"}, 16'(instr_valid),    16'(v.e_iv));
        check({tag, ".halted"},      16'(halted),         16'(v.e_h));
        check({tag, ".state"},       16'(state),          16'(v.e_st));
        check({tag, ".load_ready"},  16'(load_ready),     16'(v.e_lr));
    endtask

    initial begin
        rst = 1'b0; load_en = 1'b0; load_valid = 1'b0; load_data = '0;
        run = 1'b0; step = 1'b0; stall = 1'b0; jump_valid = 1'b0; jump_target = '0;

        //                r le lv data      rn st sl jv jt   pc  instr     iv h st lr
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 16'h1111, 0, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 16'h2222, 0, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 16'hFFFF, 0, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 1, 16'hAAAA, 0, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0,  1, 16'h1111, 1, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0,  2, 16'h2222, 1, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0,  3, 16'hFFFF, 1, 1, 3, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0,  3, 16'hFFFF, 0, 1, 3, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 0,  3, 16'hFFFF, 0, 1, 3, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 1, 0,  3, 16'hFFFF, 0, 1, 3, 0));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0,  3, 16'hFFFF, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 16'h1000, 0, 0, 0, 0, 0,  3, 16'hFFFF, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 16'h1001, 0, 0, 0, 0, 0,  3, 16'hFFFF, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 16'h1002, 0, 0, 0, 0, 0,  3, 16'hFFFF, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 16'h1003, 0, 0, 0, 0, 0,  3, 16'hFFFF, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 16'h1004, 0, 0, 0, 0, 0,  3, 16'hFFFF, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0,  0, 16'hFFFF, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 0,  1, 16'h1000, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0,  1, 16'h1000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 0,  2, 16'h1001, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0,  2, 16'h1001, 0, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0,  3, 16'h1002, 1, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 0, 0,  3, 16'h1002, 0, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 0, 0,  3, 16'h1002, 0, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 1, 0,  3, 16'h1002, 0, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0,  4, 16'h1003, 1, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 1, 0,  0, 16'h1003, 0, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0,  1, 16'h1000, 1, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0,  2, 16'h1001, 1, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 1, 0,  0, 16'h1001, 0, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0,  1, 16'h1000, 1, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0,  1, 16'h1000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0,  1, 16'h1000, 0, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0,  2, 16'h1001, 1, 0, 2, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 0,  1, 16'h1000, 1, 0, 0, 0));

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        // Load 17 words into a 16-deep memory: the 17th overwrites mem[0].
        apply(mk(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h1000, 0, 0, 1, 1), "wrap.enter");
        for (int i = 0; i < 17; i++)
            apply(mk(1, 1, 1, 16'h2000 + 16'(i), 0, 0, 0, 0, 0, 1, 16'h1000, 0, 0, 1, 1),
                  $sformatf("wrap.load%0d", i));
        apply(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h1000, 0, 0, 0, 0), "wrap.exit");
        apply(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h2010, 1, 0, 0, 0), "wrap.step0");
        apply(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 2, 16'h2001, 1, 0, 0, 0), "wrap.step1");
        apply(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 2, 16'h2001, 0, 0, 2, 0), "wrap.run");
        // Fetch through the top of memory; pc wraps 15 -> 0.
        for (int k = 2; k < 16; k++)
            apply(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'((k + 1) % 16), 16'h2000 + 16'(k),
                     1, 0, 2, 0), $sformatf("wrap.fetch%0d", k));
        apply(mk(1, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 1, 16'h2010, 1, 0, 2, 0), "wrap.fetch16");
        apply(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h2010, 0, 0, 0, 0), "wrap.idle");

        // Reset in the middle of a load keeps the words already written.
        apply(mk(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h2010, 0, 0, 1, 1), "rstld.enter");
        apply(mk(1, 1, 1, 16'h3333, 0, 0, 0, 0, 0, 1, 16'h2010, 0, 0, 1, 1), "rstld.w0");
        apply(mk(0, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0), "rstld.rst");
        apply(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h3333, 1, 0, 0, 0), "rstld.step0");
        apply(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 2, 16'h2001, 1, 0, 0, 0), "rstld.step1");

        // Single-step onto a halt word still halts.
        apply(mk(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 2, 16'h2001, 0, 0, 1, 1), "sthalt.enter");
        apply(mk(1, 1, 1, 16'hFFFF, 0, 0, 0, 0, 0, 2, 16'h2001, 0, 0, 1, 1), "sthalt.w0");
        apply(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h2001, 0, 0, 0, 0), "sthalt.exit");
        apply(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 1, 16'hFFFF, 1, 1, 3, 0), "sthalt.step");
        apply(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 1, 16'hFFFF, 0, 1, 3, 0), "sthalt.hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
